// File: rtl/pp_gen_pipe_pkg.sv
// pp_gen_pipe_pkg: shared widths, occupancy states and the partial-product generator.
package pp_gen_pipe_pkg;

    localparam int OPW = 8;
    localparam int PPW = OPW * OPW;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    // Baugh-Wooley flips every sign-row or sign-column bit except the sign*sign corner.
    function automatic logic [PPW-1:0] pp_bw(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                             input logic signed_mode);
        logic [PPW-1:0] pp;
        pp = '0;
        for (int i = 0; i < OPW; i++) begin
            for (int j = 0; j < OPW; j++) begin
                pp[OPW*i+j] = (a[j] & b[i]) ^ (signed_mode & ((i == OPW-1) ^ (j == OPW-1)));
            end
        end
        return pp;
    endfunction

endpackage

// File: rtl/pp_skid_buf.sv
// pp_skid_buf: 2-entry valid/ready skid buffer with registered ready and a flushing clear.
module pp_skid_buf
    import pp_gen_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    occ_e         state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q, rdy_d;
    logic         acc, oxf;

    assign in_rdy   = rdy_q;
    assign out_vld  = (state_q != EMPTY);
    assign out_data = main_q;

    always_comb begin
        acc     = in_vld & rdy_q & ~clr;
        oxf     = out_vld & out_rdy;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (acc) begin
                state_d = ONE;
                main_d  = in_data;
            end
            ONE: if (acc && oxf) begin
                main_d  = in_data;
            end else if (acc) begin
                state_d = TWO;
                skid_d  = in_data;
            end else if (oxf) begin
                state_d = EMPTY;
            end
            TWO: if (oxf) begin
                state_d = ONE;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        if (clr) state_d = EMPTY;
        rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (state_q inside {EMPTY, ONE, TWO});
    end

endmodule

// File: rtl/pp_gen_pipe.sv
// pp_gen_pipe: generates the 8x8 partial-product bus and presents it through a skid buffer.
module pp_gen_pipe
    import pp_gen_pipe_pkg::*;
#(
    parameter int SIGNED = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [PPW-1:0]   out_pp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam int W = PPW + TAG_W + 1;

    logic [W-1:0] in_data, out_data;

    assign in_data = {pp_bw(in_a, in_b, SIGNED != 0), in_tag, (in_a == '0) || (in_b == '0)};
    assign {out_pp, out_tag, out_zero} = out_data;

    pp_skid_buf #(.W(W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_data(out_data)
    );

endmodule

// File: doc/pp_gen_pipe.md
Name: pp_gen_pipe

Overview:
- Producer side of the 64-bit partial-product bus that the 8x8 approximate compressor tree consumes.
- Accepts 8-bit operand pairs over a valid/ready handshake and generates the 64 partial-product bits, Baugh-Wooley in signed mode.
- Presents them on a registered, back-pressurable output with a 2-entry skid buffer, so the multiplier datapath can be pipelined and stalled.

Parameters:
- SIGNED, 1: 1 = Baugh-Wooley signed pp generation; 0 = plain unsigned AND array.
- TAG_W, 4: width of the sideband tag carried alongside each operand pair.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; drops all buffered entries.
- in_vld  input  1  operand pair valid.
- in_rdy  output  1  block can accept; registered.
- in_a  input  8  multiplicand.
- in_b  input  8  multiplier.
- in_tag  input  TAG_W  sideband tag.
- out_vld  output  1  pp bus valid.
- out_rdy  input  1  downstream accepts.
- out_pp  output  64  partial products; bits [8i+j] = row i (multiplier bit i), column j (weight i+j).
- out_tag  output  TAG_W  tag of the presented entry.
- out_zero  output  1  in_a==0 or in_b==0 at capture; lets downstream skip the tree.

Behaviour:
- Reset: rst_n low asynchronously clears occupancy to 0. Outputs during and after reset: out_vld=0, in_rdy=1, out_pp=0, out_tag=0, out_zero=0.
- Handshake rules:
  - Transfer on a clock edge when vld&rdy are both high.
  - out_pp, out_tag and out_zero hold stable while out_vld=1 and out_rdy=0.
  - out_vld never drops without a transfer, except on clr.
- pp generation is combinational from in_a/in_b and captured at accept; there is no stored operand.
  - SIGNED=0: pp[8i+j] = in_a[j] & in_b[i].
  - SIGNED=1: same, except the 7 bits pp[8i+7] for i<7 and the 7 bits pp[56+j] for j<7 are inverted. pp[63] = in_a[7]&in_b[7], not inverted.
  - The +1 constants at weights 8 and 15 belong to the consumer; they are not encoded here.
- Storage: main register (drives outputs) plus a skid register. Occupancy state is EMPTY, ONE or TWO.
  - EMPTY: accept -> ONE. Data goes to main; out_vld rises the next cycle, so latency is 1 cycle.
  - ONE, out xfer only -> EMPTY.
  - ONE, accept only -> TWO; new data goes to skid.
  - ONE, accept and out xfer in the same cycle -> ONE; main is replaced by the new data.
  - TWO, out xfer -> ONE; skid moves to main.
  - TWO: no accept is possible because in_rdy=0.
- in_rdy = (state != TWO), registered from next-state. Throughput is 1 entry/cycle while out_rdy=1.
- Simultaneous events:
  - clr has priority over everything in the same cycle: next state EMPTY, no accept, in_rdy=1 next cycle.
  - Anything the downstream samples during a clr cycle is still a legal transfer.
- Reset mid-operation: all entries are discarded and no spurious out_vld is produced after release.
- Order is strict FIFO; the tag stays attached to its entry.
- Occupancy never exceeds 2, and assertions must check this. An in_vld held while in_rdy=0 must not be consumed.

Decomposition:
- Shared package holds:
  - OPW = 8.
  - PPW = OPW*OPW = 64.
  - Occupancy enum EMPTY/ONE/TWO.
  - A function pp_bw(a, b, signed_mode) returning the 64-bit vector, also reused by the bench reference model.
- One sub-module, pp_skid_buf: a generic 2-entry valid/ready skid buffer over the {pp, tag, zero} payload. The top module is the pp function plus this buffer.

Test Plan:
- SIGNED=1, a=0x00, b=0x00, out_rdy=1 -> one cycle later out_vld=1, out_pp=0x7F80808080808080, out_zero=1.
- SIGNED=1, a=0xFF, b=0xFF -> out_pp=0x807F7F7F7F7F7F7F, out_zero=0. The pp vector fed through the compressor model, plus the constants, gives 0x0001.
- SIGNED=0, a=0xFF, b=0xFF -> out_pp=0xFFFFFFFFFFFFFFFF.
- Back-pressure: stream tags 1,2,3 with out_rdy=0 -> tags 1 and 2 are accepted, in_rdy=0 on the 3rd. Then out_rdy=1 -> outputs 1,2,3 in order, with no loss or duplication.
- Back-to-back streaming: 100 random pairs with out_rdy=1 -> one output per cycle and every out_pp equals pp_bw of its inputs.
- clr in state TWO with in_vld=1 -> next cycle out_vld=0, in_rdy=1, and the held entry is not accepted. Asserting rst_n=0 mid-stream -> out_vld drops immediately.
